aon_clkdiv_ctrl: RTL and testbench

//  Run-time programmable, glitch-free clock divider controller for the AON clock path. Generates clk_out

---
 rtl/aon_clkdiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_aon_clkdiv_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aon_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aon_clkdiv_ctrl
//  Purpose  : Run-time programmable, glitch-free clock divider for the AON
//             clock path. The divide ratio is 2*(cur_half+1). Ratio changes
//             arrive over a valid/ready handshake, and the block is started
//             and stopped with en. Both kinds of change are applied only on
//             period boundaries, so clk_out never carries a runt pulse.
//  Ports    : clk        - system clock
//             reset      - asynchronous reset, active low (0 = reset)
//             en         - 1 = run; 0 = stop at the next period end
//             cfg_valid  - a new half-period value is offered
//             cfg_half   - new half-period minus 1 (0 = divide-by-2)
//             cfg_ready  - no config pending; cfg_valid is accepted now
//             clk_out    - divided clock, driven directly from a flop
//             rise_tick  - high in the first clk cycle that clk_out reads 1
//             running    - block is not idle
//             cur_half   - half-period value currently in use
//  Revision : 1.0 - initial release
// ============================================================================
module aon_clkdiv_ctrl #(
    parameter int unsigned          CNT_W        = 16,
    parameter logic [CNT_W-1:0]     DEFAULT_HALF = CNT_W'(127)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_half
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_half;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_rise_tick;

    logic w_active;
    logic w_half_end;
    logic w_period_end;
    logic w_xfer;

    // A half-period ends when the counter reaches cur_half; the period ends
    // on the half-period end that drops clk_out.
    assign w_active     = (r_state != S_IDLE);
    assign w_half_end   = w_active && (r_cnt == r_cur_half);
    assign w_period_end = w_half_end && r_clk_out;
    assign w_xfer       = cfg_valid && !r_pending;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!en) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Re-enabling before the period end resumes seamlessly.
                if (en)                w_state_nxt = S_RUN;
                else if (w_period_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        running   = (r_state != S_IDLE);
        cfg_ready = !r_pending;
    end

    assign clk_out   = r_clk_out;
    assign rise_tick = r_rise_tick;
    assign cur_half  = r_cur_half;

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_clk_out   <= 1'b0;
            r_rise_tick <= 1'b0;
        end else begin
            // Leaving STOP at a period end lands at cnt=0 / clk_out=0, the
            // same values the idle branch holds, so no special case is needed.
            if (!w_active) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
            end else if (w_half_end) begin
                r_cnt     <= '0;
                r_clk_out <= !r_clk_out;
            end else begin
                r_cnt     <= r_cnt + 1'b1;
            end
            r_rise_tick <= w_half_end && !r_clk_out;
        end
    end

    // ------------------------------------------------------------------
    // Configuration handshake
    // ------------------------------------------------------------------
    // When idle, a new value is applied at once. While active it is parked
    // in pend_half and applied at the next period end; because that check
    // uses the registered pending flag, a transfer that coincides with a
    // period end waits for the following one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_half  <= DEFAULT_HALF;
            r_pend_half <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (!w_active && w_xfer) begin
                r_cur_half <= cfg_half;
            end else if (w_period_end && r_pending) begin
                r_cur_half <= r_pend_half;
            end

            if (w_period_end && r_pending) begin
                r_pending <= 1'b0;
            end else if (w_active && w_xfer) begin
                r_pending   <= 1'b1;
                r_pend_half <= cfg_half;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aon_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aon_clkdiv_ctrl
//  Purpose  : Self-checking bench for aon_clkdiv_ctrl. It applies a vector
//             table, hand-written multi-cycle sequences, and randomized
//             stimulus compared against a period-position reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aon_clkdiv_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             clk_out;
    logic             rise_tick;
    logic             running;
    logic [CNT_W-1:0] cur_half;

    int n_chk = 0;
    int n_err = 0;

    aon_clkdiv_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (16'd127)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .running   (running),
        .cur_half  (cur_half)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: position within the output period. A period has
    // 2*(h+1) positions; clk_out is high for positions h+1 .. 2h+1.
    // ------------------------------------------------------------------
    bit m_on, m_stop, m_pend;
    int m_h, m_pend_h, m_pos;

    task automatic model_reset();
        m_on = 0; m_stop = 0; m_pend = 0;
        m_h = 127; m_pend_h = 0; m_pos = 0;
    endtask

    task automatic model_step();
        bit xfer;
        bit last;
        xfer = cfg_valid && !m_pend;
        if (!m_on) begin
            if (xfer) m_h = int'(cfg_half);
            if (en) begin
                m_on = 1; m_stop = 0;
            end
            m_pos = 0;
        end else begin
            last = (m_pos == 2 * m_h + 1);
            if (last) begin
                m_pos = 0;
                if (m_pend) begin
                    m_h = m_pend_h; m_pend = 0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            if (xfer) begin
                m_pend = 1; m_pend_h = int'(cfg_half);
            end
            if (m_stop) begin
                if (en)        m_stop = 0;
                else if (last) m_on = 0;
            end else if (!en) begin
                m_stop = 1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        #12;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // Ticks until clk_out reads val; n is the number of ticks taken.
    task automatic wait_level(input logic val, input int limit, output int n);
        n = 0;
        while (clk_out !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic        en;
        logic        cv;
        logic [15:0] ch;
        int          cyc;
        logic        x_clk;
        logic        x_tick;
        logic        x_run;
        logic        x_rdy;
        logic [15:0] x_half;
    } vec_t;

    vec_t vecs [22];

    initial begin
        int n;
        int ticks;

        //            en  cv  ch    cyc clk tck run rdy half
        vecs[0]  = '{1'b0,1'b0,16'd0,1, 1'b0,1'b0,1'b0,1'b1,16'd127};
        vecs[1]  = '{1'b0,1'b1,16'd3,1, 1'b0,1'b0,1'b0,1'b1,16'd3};
        vecs[2]  = '{1'b1,1'b0,16'd0,1, 1'b0,1'b0,1'b1,1'b1,16'd3};
        vecs[3]  = '{1'b1,1'b0,16'd0,3, 1'b0,1'b0,1'b1,1'b1,16'd3};
        vecs[4]  = '{1'b1,1'b0,16'd0,1, 1'b1,1'b1,1'b1,1'b1,16'd3};
        vecs[5]  = '{1'b1,1'b0,16'd0,3, 1'b1,1'b0,1'b1,1'b1,16'd3};
        vecs[6]  = '{1'b1,1'b1,16'd1,1, 1'b0,1'b0,1'b1,1'b0,16'd3};
        vecs[7]  = '{1'b1,1'b0,16'd0,3, 1'b0,1'b0,1'b1,1'b0,16'd3};
        vecs[8]  = '{1'b1,1'b0,16'd0,1, 1'b1,1'b1,1'b1,1'b0,16'd3};
        vecs[9]  = '{1'b1,1'b0,16'd0,3, 1'b1,1'b0,1'b1,1'b0,16'd3};
        vecs[10] = '{1'b1,1'b0,16'd0,1, 1'b0,1'b0,1'b1,1'b1,16'd1};
        vecs[11] = '{1'b1,1'b0,16'd0,2, 1'b1,1'b1,1'b1,1'b1,16'd1};
        vecs[12] = '{1'b0,1'b0,16'd0,1, 1'b1,1'b0,1'b1,1'b1,16'd1};
        vecs[13] = '{1'b0,1'b0,16'd0,1, 1'b0,1'b0,1'b0,1'b1,16'd1};
        vecs[14] = '{1'b0,1'b1,16'd0,1, 1'b0,1'b0,1'b0,1'b1,16'd0};
        vecs[15] = '{1'b1,1'b0,16'd0,1, 1'b0,1'b0,1'b1,1'b1,16'd0};
        vecs[16] = '{1'b1,1'b0,16'd0,1, 1'b1,1'b1,1'b1,1'b1,16'd0};
        vecs[17] = '{1'b1,1'b0,16'd0,1, 1'b0,1'b0,1'b1,1'b1,16'd0};
        vecs[18] = '{1'b1,1'b0,16'd0,1, 1'b1,1'b1,1'b1,1'b1,16'd0};
        vecs[19] = '{1'b1,1'b1,16'd2,1, 1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[20] = '{1'b0,1'b0,16'd0,1, 1'b1,1'b1,1'b1,1'b0,16'd0};
        vecs[21] = '{1'b0,1'b0,16'd0,1, 1'b0,1'b0,1'b0,1'b1,16'd2};

        // ---------------- Vector table ----------------
        do_reset();
        for (int i = 0; i < 22; i++) begin
            en = vecs[i].en; cfg_valid = vecs[i].cv; cfg_half = vecs[i].ch;
            repeat (vecs[i].cyc) tick();
            check($sformatf("vec%0d_clk_out", i),   32'(clk_out),   32'(vecs[i].x_clk));
            check($sformatf("vec%0d_rise_tick", i), 32'(rise_tick), 32'(vecs[i].x_tick));
            check($sformatf("vec%0d_running", i),   32'(running),   32'(vecs[i].x_run));
            check($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].x_rdy));
            check($sformatf("vec%0d_cur_half", i),  32'(cur_half),  32'(vecs[i].x_half));
        end

        // ---------------- Default divide-by-256 ----------------
        do_reset();
        en = 1'b1;
        tick();
        check("dflt_running", 32'(running), 32'd1);
        check("dflt_cur_half", 32'(cur_half), 32'd127);
        wait_level(1'b1, 400, n);
        check("dflt_first_rise", 32'(n), 32'd128);
        check("dflt_rise_tick", 32'(rise_tick), 32'd1);
        ticks = 0;
        wait_level(1'b0, 400, n);
        check("dflt_high_time", 32'(n), 32'd128);
        wait_level(1'b1, 400, n);
        check("dflt_low_time", 32'(n), 32'd128);

        // ---------------- Config while running ----------------
        repeat (10) tick();
        cfg_valid = 1'b1; cfg_half = 16'd1;
        tick();
        cfg_valid = 1'b0; cfg_half = 16'd9;
        check("run_cfg_ready_low", 32'(cfg_ready), 32'd0);
        check("run_cfg_half_held", 32'(cur_half), 32'd127);
        wait_level(1'b0, 400, n);
        check("run_cfg_fall", 32'(n), 32'd117);
        check("run_cfg_ready_back", 32'(cfg_ready), 32'd1);
        check("run_cfg_applied", 32'(cur_half), 32'd1);
        wait_level(1'b1, 20, n);
        check("run_new_low", 32'(n), 32'd2);
        wait_level(1'b0, 20, n);
        check("run_new_high", 32'(n), 32'd2);

        // ---------------- Stop mid high phase ----------------
        do_reset();
        en = 1'b1;
        tick();
        wait_level(1'b1, 400, n);
        repeat (5) tick();
        en = 1'b0;
        tick();
        check("stop_still_running", 32'(running), 32'd1);
        wait_level(1'b0, 400, n);
        check("stop_fall", 32'(n), 32'd122);
        check("stop_idle", 32'(running), 32'd0);
        repeat (3) tick();
        check("stop_clk_low", 32'(clk_out), 32'd0);
        check("stop_idle_hold", 32'(running), 32'd0);

        // ---------------- en glitch inside a period ----------------
        do_reset();
        en = 1'b1;
        tick();
        wait_level(1'b1, 400, n);
        repeat (5) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_level(1'b0, 400, n);
        check("glitch_fall", 32'(n), 32'd120);
        check("glitch_running", 32'(running), 32'd1);
        wait_level(1'b1, 400, n);
        check("glitch_low", 32'(n), 32'd128);

        // ---------------- Async reset mid high phase ----------------
        cfg_valid = 1'b1; cfg_half = 16'd5;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("areset_pending", 32'(cfg_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("areset_clk_out", 32'(clk_out), 32'd0);
        check("areset_running", 32'(running), 32'd0);
        check("areset_cur_half", 32'(cur_half), 32'd127);
        check("areset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("areset_rise_tick", 32'(rise_tick), 32'd0);

        // ---------------- Randomized vs reference model ----------------
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            check("rnd_clk_out",   32'(clk_out),   32'(m_on && (m_pos > m_h)));
            check("rnd_rise_tick", 32'(rise_tick), 32'(m_on && (m_pos == m_h + 1)));
            check("rnd_running",   32'(running),   32'(m_on));
            check("rnd_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
            check("rnd_cur_half",  32'(cur_half),  32'(m_h));
            if ($urandom_range(0, 39) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) cfg_half = 16'($urandom_range(0, 24));
            else                           cfg_half = 16'($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
